// File: rtl/reg_alu_ctrl.sv
// reg_alu_ctrl: 8 x W register file and issue controller for an external ripple ALU.
// Accepts one micro-instruction per valid/ready handshake; loads or ALU ops write back.
`default_nettype none

module reg_alu_ctrl #(
  parameter int W     = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          instr_sel,
  input  logic [1:0]    instr_op,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  d_in,
  output logic [1:0]    alu_op,
  output logic [W-1:0]  alu_i0,
  output logic [W-1:0]  alu_i1,
  input  logic [W-1:0]  alu_o,
  input  logic          alu_cout,
  output logic [W-1:0]  result,
  output logic          carry_flag,
  output logic          done,
  input  logic [AW-1:0] dbg_rd_addr,
  output logic [W-1:0]  dbg_rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPRD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  rf [NREGS];
  logic [1:0]    op_q;
  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] wr_q;
  logic          accept;

  // Ready is forced low while reset is asserted, even though state is already IDLE.
  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign dbg_rd_data = rf[dbg_rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wr_q       <= '0;
      alu_op     <= '0;
      alu_i0     <= '0;
      alu_i1     <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= instr_op;
            a_q  <= rd_addr_a;
            b_q  <= rd_addr_b;
            wr_q <= wr_addr;
            if (instr_sel) begin
              // Loads skip the ALU; the staged value goes straight to write-back.
              result <= d_in;
              done   <= 1'b1;
              state  <= WB;
            end else begin
              state <= OPRD;
            end
          end
        end
        OPRD: begin
          alu_i0 <= rf[a_q];
          alu_i1 <= rf[b_q];
          alu_op <= op_q;
          state  <= EXEC;
        end
        EXEC: begin
          result     <= alu_o;
          carry_flag <= alu_cout;
          done       <= 1'b1;
          state      <= WB;
        end
        WB: begin
          rf[wr_q] <= result;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_alu_ctrl.sv
// tb_reg_alu_ctrl: scoreboard bench with an array-based reference model and an ALU stub.
`default_nettype none

module tb_reg_alu_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_sel;
  logic [1:0]  instr_op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic [1:0]  alu_op;
  logic [15:0] alu_i0;
  logic [15:0] alu_i1;
  logic [15:0] alu_o;
  logic        alu_cout;
  logic [15:0] result;
  logic        carry_flag;
  logic        done;
  logic [2:0]  dbg_rd_addr;
  logic [15:0] dbg_rd_data;

  reg_alu_ctrl #(.W(16), .NREGS(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_sel(instr_sel), .instr_op(instr_op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .result(result), .carry_flag(carry_flag), .done(done),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
  );

  // External ALU stand-in: add with carry-in taken from op[0].
  logic [16:0] alu_sum;
  assign alu_sum  = {1'b0, alu_i0} + {1'b0, alu_i1} + {16'd0, alu_op[0]};
  assign alu_o    = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          alu;
    logic [15:0] res;
    logic        carry;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [1:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_rf [8];
  logic        m_carry;
  bit          b2b;
  int          exp_waits;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.carry});
        if (e.alu) begin
          chk("alu_i0", {16'd0, alu_i0}, {16'd0, e.i0});
          chk("alu_i1", {16'd0, alu_i1}, {16'd0, e.i1});
          chk("alu_op", {30'd0, alu_op}, {30'd0, e.op});
        end
      end
    end
  end

  // Called and returns at a negedge; instr_valid stays high on return.
  task automatic issue(input bit sel, input logic [1:0] op, input int a, input int b,
                       input int wr, input logic [15:0] d, input bit track);
    int          waits;
    exp_t        e;
    logic [16:0] s;
    instr_valid = 1'b1;
    instr_sel   = sel;
    instr_op    = op;
    rd_addr_a   = 3'(a);
    rd_addr_b   = 3'(b);
    wr_addr     = 3'(wr);
    d_in        = d;
    waits       = 0;
    while (!instr_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    if (b2b) chk("ready_low_cycles", waits, exp_waits);
    e.cyc   = cyc + (sel ? 1 : 3);
    e.alu   = !sel;
    e.op    = op;
    e.i0    = m_rf[a];
    e.i1    = m_rf[b];
    if (sel) begin
      e.res   = d;
      e.carry = m_carry;
    end else begin
      s       = {1'b0, m_rf[a]} + {1'b0, m_rf[b]} + {16'd0, op[0]};
      e.res   = s[15:0];
      e.carry = s[16];
    end
    if (track) begin
      sb.push_back(e);
      m_rf[wr] = e.res;
      m_carry  = e.carry;
    end
    exp_waits = sel ? 1 : 3;
    b2b       = 1'b1;
    @(posedge clk);
    // Scramble inputs after acceptance; the DUT must have sampled them already.
    @(negedge clk);
    instr_op  = 2'($urandom);
    rd_addr_a = 3'($urandom);
    rd_addr_b = 3'($urandom);
    wr_addr   = 3'($urandom);
    d_in      = 16'($urandom);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
    b2b = 1'b0;
  endtask

  task automatic check_regs(input string name);
    instr_valid = 1'b0;
    b2b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dbg_rd_addr = 3'(i);
      #1;
      chk(name, {16'd0, dbg_rd_data}, {16'd0, m_rf[i]});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_sel = 1'b0; instr_op = 2'd0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_addr = 3'd0; d_in = 16'd0; dbg_rd_addr = 3'd0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    m_carry = 1'b0; b2b = 1'b0; exp_waits = 0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
    chk("carry_after_reset", {31'd0, carry_flag}, 32'd0);
    chk("done_after_reset", {31'd0, done}, 32'd0);
    check_regs("reg_after_reset");

    // Load R3 and observe old value during WB, new value one cycle later.
    @(negedge clk);
    dbg_rd_addr = 3'd3;
    issue(1'b1, 2'd0, 0, 0, 3, 16'h1234, 1'b1);
    #1 chk("dbg_old_in_wb", {16'd0, dbg_rd_data}, 32'h0);
    idle(1);
    #1 chk("dbg_load_r3", {16'd0, dbg_rd_data}, 32'h1234);

    // Add R1 + R2 -> R4.
    issue(1'b1, 2'd0, 0, 0, 1, 16'h0005, 1'b1);
    issue(1'b1, 2'd0, 0, 0, 2, 16'h0003, 1'b1);
    issue(1'b0, 2'd0, 1, 2, 4, 16'h0, 1'b1);
    idle(4);
    dbg_rd_addr = 3'd4;
    #1 chk("r4_add", {16'd0, dbg_rd_data}, 32'h0008);

    // Overflow into R5, then a load must keep carry set.
    issue(1'b1, 2'd0, 0, 0, 1, 16'hFFFF, 1'b1);
    issue(1'b1, 2'd0, 0, 0, 2, 16'h0001, 1'b1);
    issue(1'b0, 2'd0, 1, 2, 5, 16'h0, 1'b1);
    issue(1'b1, 2'd0, 0, 0, 7, 16'hBEEF, 1'b1);
    idle(2);
    chk("carry_kept_by_load", {31'd0, carry_flag}, 32'd1);
    dbg_rd_addr = 3'd5;
    #1 chk("r5_overflow", {16'd0, dbg_rd_data}, 32'h0000);

    // Back-to-back with held valid; second reads R4 written by the first.
    issue(1'b1, 2'd0, 0, 0, 1, 16'h0010, 1'b1);
    issue(1'b1, 2'd0, 0, 0, 2, 16'h0011, 1'b1);
    issue(1'b0, 2'd0, 1, 2, 4, 16'h0, 1'b1);
    issue(1'b0, 2'd0, 4, 4, 4, 16'h0, 1'b1);
    idle(4);
    dbg_rd_addr = 3'd4;
    #1 chk("r4_doubled", {16'd0, dbg_rd_data}, 32'h0042);

    // Reset during EXEC of an add into R6.
    issue(1'b1, 2'd0, 0, 0, 6, 16'h7777, 1'b1);
    idle(2);
    issue(1'b0, 2'd1, 6, 6, 6, 16'h0, 1'b0);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("result_reset_exec", {16'd0, result}, 32'h0);
    chk("done_reset_exec", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("done_in_reset", {31'd0, done}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    m_carry = 1'b0;
    b2b = 1'b0;
    #1 chk("ready_after_exec_reset", {31'd0, instr_ready}, 32'd1);
    check_regs("reg_after_exec_reset");
    chk("pending_after_reset", sb.size(), 32'd0);

    // Randomized stream with occasional idle gaps.
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      bit sel;
      sel = ($urandom_range(0, 9) < 3);
      issue(sel, 2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 16'($urandom), 1'b1);
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    drain();
    idle(2);
    chk("final_carry", {31'd0, carry_flag}, {31'd0, m_carry});
    check_regs("final_reg");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
